// File: rtl/mem_bus_router.sv
// Address-decoding router from a single core memory port to N slave ports,
// with a per-transaction ready timeout and error reporting.
module mem_bus_router #(
  parameter int                      N_SLAVES  = 2,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE  = {32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK  = {32'hF000_0000, 32'hFFFF_0000},
  parameter int                      TIMEOUT   = 255,
  parameter logic [31:0]             ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [N_SLAVES-1:0]     s_valid,
  output logic [N_SLAVES-1:0]     s_instr,
  output logic [N_SLAVES*32-1:0]  s_addr,
  output logic [N_SLAVES*32-1:0]  s_wdata,
  output logic [N_SLAVES*4-1:0]   s_wstrb,
  input  logic [N_SLAVES-1:0]     s_ready,
  input  logic [N_SLAVES*32-1:0]  s_rdata,
  output logic                    bus_err,
  output logic                    err_timeout,
  output logic [31:0]             err_addr,
  output logic [15:0]             err_cnt
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [31:0]            addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   mem_ready_q, mem_ready_d;
  logic [31:0]            mem_rdata_q, mem_rdata_d;
  logic [N_SLAVES-1:0]    s_valid_q, s_valid_d;
  logic [N_SLAVES-1:0]    s_instr_q, s_instr_d;
  logic [N_SLAVES*32-1:0] s_addr_q, s_addr_d;
  logic [N_SLAVES*32-1:0] s_wdata_q, s_wdata_d;
  logic [N_SLAVES*4-1:0]  s_wstrb_q, s_wstrb_d;
  logic                   bus_err_q, bus_err_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [15:0]            err_cnt_q, err_cnt_d;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [SW+4:0] hit_off;
  logic [SW+4:0] sel_off;
  logic [SW+1:0] hit_soff;
  logic [15:0]   err_cnt_inc;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign hit_off     = {hit_idx, 5'd0};
  assign hit_soff    = {hit_idx, 2'd0};
  assign sel_off     = {sel_q, 5'd0};
  assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    mem_ready_d   = 1'b0;
    mem_rdata_d   = '0;
    s_valid_d     = s_valid_q;
    s_instr_d     = s_instr_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wstrb_d     = s_wstrb_q;
    bus_err_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_addr_d    = err_addr_q;
    err_cnt_d     = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && hit) begin
          sel_d                     = hit_idx;
          addr_d                    = mem_addr;
          cnt_d                     = '0;
          s_valid_d                 = '0;
          s_instr_d                 = '0;
          s_addr_d                  = '0;
          s_wdata_d                 = '0;
          s_wstrb_d                 = '0;
          s_valid_d[hit_idx]        = 1'b1;
          s_instr_d[hit_idx]        = mem_instr;
          s_addr_d[hit_off +: 32]   = mem_addr;
          s_wdata_d[hit_off +: 32]  = mem_wdata;
          s_wstrb_d[hit_soff +: 4]  = mem_wstrb;
          state_d                   = ACTIVE;
        end else if (mem_valid) begin
          mem_ready_d = 1'b1;
          mem_rdata_d = ERR_RDATA;
          bus_err_d   = 1'b1;
          err_addr_d  = mem_addr;
          err_cnt_d   = err_cnt_inc;
          state_d     = RESP;
        end
      end
      ACTIVE: begin
        if (s_ready[sel_q] || cnt_q == TMO_LAST) begin
          s_valid_d   = '0;
          s_instr_d   = '0;
          s_addr_d    = '0;
          s_wdata_d   = '0;
          s_wstrb_d   = '0;
          cnt_d       = '0;
          mem_ready_d = 1'b1;
          state_d     = RESP;
          // A ready arriving on the final wait cycle still completes cleanly
          if (s_ready[sel_q]) begin
            mem_rdata_d = s_rdata[sel_off +: 32];
          end else begin
            mem_rdata_d   = ERR_RDATA;
            bus_err_d     = 1'b1;
            err_timeout_d = 1'b1;
            err_addr_d    = addr_q;
            err_cnt_d     = err_cnt_inc;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      mem_ready_q   <= 1'b0;
      mem_rdata_q   <= '0;
      s_valid_q     <= '0;
      s_instr_q     <= '0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_wstrb_q     <= '0;
      bus_err_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_addr_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      mem_ready_q   <= mem_ready_d;
      mem_rdata_q   <= mem_rdata_d;
      s_valid_q     <= s_valid_d;
      s_instr_q     <= s_instr_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wstrb_q     <= s_wstrb_d;
      bus_err_q     <= bus_err_d;
      err_timeout_q <= err_timeout_d;
      err_addr_q    <= err_addr_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign bus_err     = bus_err_q;
  assign err_timeout = err_timeout_q;
  assign err_addr    = err_addr_q;
  assign err_cnt     = err_cnt_q;

endmodule
